normalizator_n: RTL and testbench
=================================

Name: normalizator_n

Overview:
- Iterative 32-bit normalizer for the ALU. It is the inverse of the shift-by-N units: it takes a value and finds N, instead of taking N and producing a shifted value.
- Mode 0 (stanga):
  - shifts A left until bit 31 is 1;
  - returns the shifted word and N = leading-zero count.
- Mode 1 (dreapta):
  - shifts A right until bit 0 is 1;
  - returns the shifted word and N = trailing-zero count.
- Multi-cycle binary search with a start/busy/done handshake. Used by the ALU for normalization and CLZ/CTZ operations.

Parameters:
- WIDTH, 32, datapath width. Must be a power of two, at least 2.
- NW, $clog2(WIDTH)+1, width of the N output. It must hold 0..WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request. Sampled only when the block is not busy.
- mod  input  1  0 = normalize left (leading zeros), 1 = normalize right (trailing zeros). Sampled with start.
- A  input  WIDTH  operand. Sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse: results valid.
- rezultat  output  WIDTH  normalized word. Held until the next accepted start.
- N  output  NW  shift count, 0..WIDTH. Held.
- zero  output  1  A was 0. Held.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state goes to IDLE;
  - busy = 0, done = 0, rezultat = 0, N = 0, zero = 0;
  - internal work registers are cleared.
  - This holds on entry and for as long as rst_n is low.
- Reset mid-operation aborts the operation. No done is produced. After release the block is in IDLE.
- States:
  - IDLE: waits for start.
  - PAS: the five search steps.
  - GATA: one cycle with the done pulse.
- Accept:
  - start = 1 on a rising edge while in IDLE or GATA is accepted.
  - On that edge: A is loaded into the work register W, mod is latched, count C = 0, step index k = log2(WIDTH)-1 (4 for WIDTH = 32), zero_l = (A == 0). State goes to PAS.
  - start while in PAS is ignored. The operand in flight is not disturbed.
- PAS, one step per edge, step size s = 2^k:
  - mod 0: if W[WIDTH-1 -: s] == 0, then W <= W << s and C <= C + s.
  - mod 1: if W[s-1:0] == 0, then W <= W >> s and C <= C + s.
  - Shifts are logical and zero-filling.
  - After step k = 0, state goes to GATA.
- Entering GATA (same edge as the last step):
  - rezultat <= final W.
  - N <= WIDTH if zero_l, else C. The search alone saturates at WIDTH-1, so A = 0 is forced to N = WIDTH.
  - zero <= zero_l.
  - done = 1 for exactly this cycle.
  - In GATA: start given goes to PAS (back-to-back operation); no start goes to IDLE.
- busy = 1 exactly while in PAS.
- Outputs rezultat, N and zero change only on entry to GATA. Between operations they hold their last values.
- Fixed latency:
  - the start edge is edge 1;
  - steps occur on edges 2..6;
  - done is high during the cycle after edge 6.
  - Throughput: one operation per 6 cycles with back-to-back starts.
  - Latency does not depend on the data, including A = 0.
- Invariants:
  - mod 0, A ≠ 0: rezultat[WIDTH-1] = 1 and rezultat = A << N.
  - mod 1, A ≠ 0: rezultat[0] = 1 and rezultat = A >> N.
  - A = 0: rezultat = 0, N = WIDTH, zero = 1.

Decomposition:
- Shared package normalizator_pkg:
  - state enum: IDLE, PAS, GATA;
  - mode constants: MOD_STANGA = 0, MOD_DREAPTA = 1;
  - default WIDTH.
- One combinational sub-module, normalizare_pas: one search step.
  - Inputs: W, s, mod.
  - Outputs: shifted W and a hit flag.
  - The top holds the FSM, the counters and the registers.

Test Plan:
- A = 0x00010000, mod 0 → after 6 cycles: done pulse, rezultat = 0x80000000, N = 15, zero = 0. busy is high for exactly 5 cycles.
- A = 0x00000100, mod 1 → rezultat = 0x00000001, N = 8. A = 0x80000000, mod 1 → rezultat = 0x00000001, N = 31.
- A = 0, either mode → rezultat = 0, N = 32, zero = 1, same 6-cycle latency. A = 0x80000000, mod 0 → N = 0, rezultat unchanged.
- Start with A = 0x1 (mod 0), then start with A = 0xFFFF while busy → the second request is ignored. Result is N = 31, rezultat = 0x80000000. A new start in the done cycle is accepted and its done follows 6 cycles later.
- rst_n low during step 3 → busy, done, rezultat and N go to 0 immediately (asynchronously). No done pulse appears after release. The next start completes normally.
- Random sweep of 10k operands, both modes → checked against a reference CLZ/CTZ model and the shift invariants.

Source files
------------

// File: rtl/normalizator_n_pkg.sv
// Shared types and constants for the iterative CLZ/CTZ normalizer.
package normalizator_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic MOD_STANGA  = 1'b0;
  localparam logic MOD_DREAPTA = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PAS  = 2'd1,
    GATA = 2'd2
  } state_e;

endpackage

// File: rtl/normalizator_n_if.sv
// Request/result bundle between the ALU (master) and the normalizer (slave).
interface normalizator_n_if
  import normalizator_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NW    = $clog2(WIDTH) + 1
);

  logic             start;
  logic             mod;
  logic [WIDTH-1:0] A;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rezultat;
  logic [NW-1:0]    N;
  logic             zero;

  modport master (
    output start, mod, A,
    input  busy, done, rezultat, N, zero
  );

  modport slave (
    input  start, mod, A,
    output busy, done, rezultat, N, zero
  );

endinterface

// File: rtl/normalizator_n_pas.sv
// One binary-search step: shift W by s toward the wanted end when the s bits there are all zero.
module normalizare_pas
  import normalizator_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] w_in,
  input  logic [SW-1:0]    s,
  input  logic             mod,
  output logic [WIDTH-1:0] w_out,
  output logic             hit
);

  logic [WIDTH-1:0] hi_mask;
  logic [WIDTH-1:0] lo_mask;

  // hi_mask selects the top s bits, lo_mask the bottom s bits
  assign hi_mask = ~({WIDTH{1'b1}} >> s);
  assign lo_mask = ~({WIDTH{1'b1}} << s);

  always_comb begin
    hit   = 1'b0;
    w_out = w_in;
    if (mod == MOD_DREAPTA) begin
      hit = ((w_in & lo_mask) == '0);
      if (hit) w_out = w_in >> s;
    end else begin
      hit = ((w_in & hi_mask) == '0);
      if (hit) w_out = w_in << s;
    end
  end

endmodule

// File: rtl/normalizator_n.sv
// Iterative normalizer: finds leading (mod 0) or trailing (mod 1) zero count by binary search.
module normalizator_n
  import normalizator_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  normalizator_n_if.slave  bus
);

  localparam int KW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic [NW-1:0]    c_q, c_d;
  logic [KW-1:0]    k_q, k_d;
  logic             mod_q, mod_d;
  logic             zero_l_q, zero_l_d;
  logic [WIDTH-1:0] rez_q, rez_d;
  logic [NW-1:0]    n_q, n_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [KW-1:0]    s;
  logic [WIDTH-1:0] w_step;
  logic             hit;

  assign s = KW'(1) << k_q;

  normalizare_pas #(
    .WIDTH (WIDTH),
    .SW    (KW)
  ) u_pas (
    .w_in  (w_q),
    .s     (s),
    .mod   (mod_q),
    .w_out (w_step),
    .hit   (hit)
  );

  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    c_d      = c_q;
    k_d      = k_q;
    mod_d    = mod_q;
    zero_l_d = zero_l_q;
    rez_d    = rez_q;
    n_d      = n_q;
    zero_d   = zero_q;

    case (state_q)
      IDLE, GATA: begin
        if (bus.start) begin
          state_d  = PAS;
          w_d      = bus.A;
          mod_d    = bus.mod;
          c_d      = '0;
          k_d      = KW'(KW - 1);
          zero_l_d = (bus.A == '0);
        end else begin
          state_d = IDLE;
        end
      end
      PAS: begin
        w_d = w_step;
        if (hit) c_d = c_q + NW'(s);
        if (k_q == '0) begin
          state_d = GATA;
          rez_d   = w_step;
          // the search alone tops out at WIDTH-1, so an all-zero operand is forced to WIDTH
          n_d     = zero_l_q ? NW'(WIDTH) : c_d;
          zero_d  = zero_l_q;
        end else begin
          k_d = k_q - KW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == PAS);
    done_d = (state_d == GATA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      w_q      <= '0;
      c_q      <= '0;
      k_q      <= '0;
      mod_q    <= 1'b0;
      zero_l_q <= 1'b0;
      rez_q    <= '0;
      n_q      <= '0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      c_q      <= c_d;
      k_q      <= k_d;
      mod_q    <= mod_d;
      zero_l_q <= zero_l_d;
      rez_q    <= rez_d;
      n_q      <= n_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rezultat = rez_q;
  assign bus.N        = n_q;
  assign bus.zero     = zero_q;

endmodule

// File: tb/tb_normalizator_n.sv
// Scoreboard bench for normalizator_n: expected results queued at accept, checked on done.
module tb_normalizator_n;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_vec;
  int   n_err;
  int   busy_cnt;

  typedef struct {
    logic [31:0] a;
    logic [31:0] rez;
    logic [5:0]  n;
    logic        zero;
    logic        mod;
    int          acc;
  } exp_t;

  exp_t sb[$];

  normalizator_n_if #(.WIDTH(32)) bus ();

  normalizator_n #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_clz(input logic [31:0] a);
    for (int i = 31; i >= 0; i--) if (a[i]) return 31 - i;
    return 32;
  endfunction

  function automatic int ref_ctz(input logic [31:0] a);
    for (int i = 0; i < 32; i++) if (a[i]) return i;
    return 32;
  endfunction

  // called at a negedge; returns at the following negedge with start released
  task automatic issue(input logic [31:0] a, input logic m, input bit accepted);
    exp_t e;
    int   n;
    bus.start = 1'b1;
    bus.A     = a;
    bus.mod   = m;
    @(posedge clk);
    #1;
    if (accepted) begin
      n      = (m == 1'b1) ? ref_ctz(a) : ref_clz(a);
      e.a    = a;
      e.n    = 6'(n);
      e.zero = (a == 32'd0);
      e.rez  = (a == 32'd0) ? 32'd0 : ((m == 1'b1) ? (a >> n) : (a << n));
      e.mod  = m;
      e.acc  = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 12; i++) begin
      if (bus.done) return;
      @(negedge clk);
    end
    chk("done_timeout", {63'd0, bus.done}, 64'd1);
  endtask

  task automatic run_op(input logic [31:0] a, input logic m);
    issue(a, m, 1'b1);
    wait_done();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", {63'd0, bus.done}, 64'd0);
        end else begin
          e = sb.pop_front();
          $display("op a=%08h mod=%0d -> rez=%08h N=%0d zero=%0d", e.a, e.mod, bus.rezultat, bus.N, bus.zero);
          chk("rezultat", {32'd0, bus.rezultat}, {32'd0, e.rez});
          chk("N", {58'd0, bus.N}, {58'd0, e.n});
          chk("zero", {63'd0, bus.zero}, {63'd0, e.zero});
          chk("latency", 64'(cyc - e.acc), 64'd5);
          chk("busy_cycles", 64'(busy_cnt), 64'd5);
          if (!e.zero && e.mod == 1'b0) begin
            chk("inv_msb", {63'd0, bus.rezultat[31]}, 64'd1);
            chk("inv_shl", {32'd0, bus.rezultat}, {32'd0, e.a << bus.N});
          end
          if (!e.zero && e.mod == 1'b1) begin
            chk("inv_lsb", {63'd0, bus.rezultat[0]}, 64'd1);
            chk("inv_shr", {32'd0, bus.rezultat}, {32'd0, e.a >> bus.N});
          end
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    logic [31:0] a;
    n_vec     = 0;
    n_err     = 0;
    busy_cnt  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.mod   = 1'b0;
    bus.A     = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_rez", {32'd0, bus.rezultat}, 64'd0);
    chk("rst_N", {58'd0, bus.N}, 64'd0);
    chk("rst_zero", {63'd0, bus.zero}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(32'h0001_0000, 1'b0);
    repeat (2) @(negedge clk);
    run_op(32'h0000_0100, 1'b1);
    run_op(32'h8000_0000, 1'b1);
    run_op(32'h0000_0000, 1'b0);
    run_op(32'h0000_0000, 1'b1);
    run_op(32'h8000_0000, 1'b0);
    repeat (3) @(negedge clk);

    // second start while busy must be dropped
    issue(32'h0000_0001, 1'b0, 1'b1);
    issue(32'h0000_FFFF, 1'b0, 1'b0);
    wait_done();
    run_op(32'h0000_005A, 1'b1);
    repeat (2) @(negedge clk);

    // asynchronous reset in the middle of the search
    issue(32'h1234_5678, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {63'd0, bus.busy}, 64'd0);
    chk("arst_done", {63'd0, bus.done}, 64'd0);
    chk("arst_rez", {32'd0, bus.rezultat}, 64'd0);
    chk("arst_N", {58'd0, bus.N}, 64'd0);
    chk("arst_zero", {63'd0, bus.zero}, 64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    run_op(32'h00F0_0000, 1'b1);
    run_op(32'h0000_0003, 1'b0);

    for (int i = 0; i < 10000; i++) begin
      a = $urandom;
      a = a >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) a = a << $urandom_range(0, 31);
      if ($urandom_range(0, 63) == 0) a = 32'd0;
      run_op(a, 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
